ir_coeff_bank: RTL and testbench
================================

Name: ir_coeff_bank

Overview:
Runtime-loadable, double-buffered impulse-response coefficient store for the cabinet FIR engine; replaces the fixed 256x16 generated weight table. Host/loader writes a new IR into the shadow bank over a valid/ready stream while the FIR engine streams the active bank. A commit swaps banks only on a FIR frame boundary, so coefficients never change mid-convolution. An unloaded bank reads as a unit impulse (passthrough cabinet).

Parameters:
TAPS, 256, number of coefficients per IR; power of two, 16..4096.
WORD_W, 16, coefficient width, signed two's complement Q1.(WORD_W-1).
ADDR_W, $clog2(TAPS), tap index width (derived, not overridden).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin loading shadow bank at tap 0
load_valid  in  1  load word valid
load_data  in  WORD_W  coefficient, tap order 0..TAPS-1
load_ready  out  1  bank accepts load word
load_done  out  1  1-cycle pulse: last tap written
commit  in  1  pulse: request shadow->active swap
swap_pending  out  1  commit accepted, swap not yet done
swapped  out  1  1-cycle pulse on the swap edge
rd_start  in  1  pulse: stream active bank to FIR engine
rd_valid  out  1  rd_data valid
rd_data  out  WORD_W  coefficient
rd_idx  out  ADDR_W  tap index of rd_data
rd_last  out  1  with final tap
rd_busy  out  1  stream in progress (rd_start accepted to rd_last)

Behaviour:
- Reset (async assert, sync deassert via rst_n already synchronised): load FSM IDLE, active_sel=0, loaded[1:0]=0, swap_pending=0, all outputs 0 (load_ready=0). RAM contents not reset.
- Load FSM: IDLE -> LOAD on load_start; LOAD: load_ready=1, word written to shadow bank at waddr when load_valid&&load_ready, waddr++; on write of waddr==TAPS-1 -> FULL, load_done pulses next cycle, loaded[shadow]=1. FULL: load_ready=0; commit -> SWAP; SWAP: waits, then -> IDLE on swap edge.
- load_start in LOAD or FULL: restart at waddr=0, loaded[shadow] cleared. load_start in SWAP ignored. commit outside FULL ignored.
- Clearing: loaded[shadow] cleared on entry to LOAD.
- Swap: occurs on first edge where state==SWAP and rd_busy==0 and rd_start==0; active_sel toggles, swapped pulses, swap_pending drops. swap_pending=1 throughout SWAP.
- Read stream: rd_start sampled when rd_busy==0 -> rd_busy=1 next cycle; synchronous RAM read, rd_valid high for exactly TAPS consecutive cycles starting 2 cycles after rd_start edge; rd_idx 0..TAPS-1; rd_last with idx TAPS-1; rd_busy drops the cycle after rd_last. No backpressure. rd_start while busy ignored.
- Unloaded active bank: rd_data = 2^(WORD_W-1)-1 at idx 0, 0 elsewhere.
- rd_start and swap-eligibility in same cycle: rd_start wins, swap deferred until that stream ends.
- Reset mid-load/stream: all aborted; both banks unloaded (impulse).

Optional Feature:
IR_BANK_CHECKSUM_EN: adds ports load_sum (in, WORD_W) and load_err (out, 1). Loader accumulates modulo-2^WORD_W sum of accepted words; at FULL, commit compares with load_sum: match -> SWAP; mismatch -> load_err pulses 1 cycle, state -> IDLE, loaded[shadow] cleared, no swap. Without macro: ports absent, commit in FULL always swaps.

Test Plan:
- Reset, rd_start -> TAPS valid words: idx0=0x7FFF, idx1..255=0x0000, rd_last at idx255, rd_busy low 1 cycle later.
- Load ramp data[i]=i, load_done, commit with idle stream -> swapped next edge; stream returns 0x0000..0x00FF.
- Commit while stream at idx 10 -> swap_pending=1 until the cycle after rd_last; that stream still old bank, next stream new data.
- load_start after 100 words, then 256 words of 0xFFFF, commit -> stream all 0xFFFF; load_valid with load_ready=0 (FULL) writes nothing.
- rst_n low at load word 50 and mid-stream -> outputs 0 immediately; after release stream is impulse.
- With IR_BANK_CHECKSUM_EN: ramp load, load_sum=0x7F80 -> swap; load_sum=0x7F81 -> load_err pulse, no swapped, stream unchanged.

Source files
------------

// File: rtl/ir_coeff_bank.sv
// ir_coeff_bank: double-buffered FIR impulse-response store; loads land in the shadow bank and swap in on a frame boundary.
// Optional feature macro IR_BANK_CHECKSUM_EN adds load_sum/load_err and gates commit on a modulo-2^WORD_W word sum.
module ir_coeff_bank #(
    parameter int unsigned TAPS   = 256,
    parameter int unsigned WORD_W = 16,
    localparam int unsigned ADDR_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
`ifdef IR_BANK_CHECKSUM_EN
    input  logic [WORD_W-1:0] load_sum,
    output logic              load_err,
`endif
    input  logic              commit,
    output logic              swap_pending,
    output logic              swapped,
    input  logic              rd_start,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              rd_last,
    output logic              rd_busy
);

    localparam int unsigned      BANK_AW  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);
    localparam logic [WORD_W-1:0] UNIT     = {1'b0, {(WORD_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_SWAP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]          loaded_q, loaded_d;
    logic                active_sel_q, active_sel_d;
    logic                load_ready_q, load_ready_d;
    logic                load_done_q, load_done_d;
    logic                swap_pending_q, swap_pending_d;
    logic                swapped_q, swapped_d;
`ifdef IR_BANK_CHECKSUM_EN
    logic [WORD_W-1:0]   sum_q, sum_d;
    logic                load_err_q, load_err_d;
`endif

    logic                rd_busy_q, rd_busy_d;
    logic                rd_issue_q, rd_issue_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]   s1_idx_q, s1_idx_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
    logic                rd_last_q, rd_last_d;

    logic [WORD_W-1:0]   bank_mem [2*TAPS];
    logic [WORD_W-1:0]   ram_rdata;

    logic                shadow_c;
    logic                wr_en_c;
    logic                restart_c;
    logic                rd_go_c;
    logic                swap_go_c;

    assign shadow_c  = ~active_sel_q;
    assign wr_en_c   = (state_q == ST_LOAD) && load_valid;
    assign restart_c = load_start && (state_q != ST_SWAP);
    assign rd_go_c   = rd_start && !rd_busy_q;
    // A starting stream always beats a pending swap; the swap waits for that frame to end.
    assign swap_go_c = (state_q == ST_SWAP) && !rd_busy_q && !rd_start;

    // Coefficient RAM: both banks in one array, bank select is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            bank_mem[BANK_AW'({shadow_c, waddr_q})] <= load_data;
        end
        if (rd_issue_q) begin
            ram_rdata <= bank_mem[BANK_AW'({active_sel_q, raddr_q})];
        end
    end

    // Load / commit / swap control.
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        loaded_d     = loaded_q;
        active_sel_d = active_sel_q;
        load_done_d  = 1'b0;
        swapped_d    = 1'b0;
`ifdef IR_BANK_CHECKSUM_EN
        sum_d        = sum_q;
        load_err_d   = 1'b0;
`endif
        if (restart_c) begin
            state_d            = ST_LOAD;
            waddr_d            = '0;
            loaded_d[shadow_c] = 1'b0;
`ifdef IR_BANK_CHECKSUM_EN
            sum_d              = '0;
`endif
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        waddr_d = waddr_q + ADDR_W'(1);
`ifdef IR_BANK_CHECKSUM_EN
                        sum_d   = sum_q + load_data;
`endif
                        if (waddr_q == LAST_IDX) begin
                            state_d            = ST_FULL;
                            load_done_d        = 1'b1;
                            loaded_d[shadow_c] = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (commit) begin
`ifdef IR_BANK_CHECKSUM_EN
                        if (sum_q == load_sum) begin
                            state_d = ST_SWAP;
                        end else begin
                            state_d            = ST_IDLE;
                            load_err_d         = 1'b1;
                            loaded_d[shadow_c] = 1'b0;
                        end
`else
                        state_d = ST_SWAP;
`endif
                    end
                end
                ST_SWAP: begin
                    if (swap_go_c) begin
                        state_d      = ST_IDLE;
                        active_sel_d = ~active_sel_q;
                        swapped_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        load_ready_d   = (state_d == ST_LOAD);
        swap_pending_d = (state_d == ST_SWAP);
    end

    // Read stream: issue stage -> RAM register -> output register (2-cycle latency).
    always_comb begin
        rd_busy_d  = rd_busy_q;
        rd_issue_d = rd_issue_q;
        raddr_d    = raddr_q;
        if (rd_go_c) begin
            rd_busy_d  = 1'b1;
            rd_issue_d = 1'b1;
            raddr_d    = '0;
        end else begin
            if (rd_last_q) begin
                rd_busy_d = 1'b0;
            end
            if (rd_issue_q) begin
                raddr_d = raddr_q + ADDR_W'(1);
                if (raddr_q == LAST_IDX) begin
                    rd_issue_d = 1'b0;
                end
            end
        end
        s1_valid_d = rd_issue_q;
        s1_idx_d   = raddr_q;
        rd_valid_d = s1_valid_q;
        rd_idx_d   = s1_idx_q;
        rd_last_d  = s1_valid_q && (s1_idx_q == LAST_IDX);
        rd_data_d  = '0;
        if (s1_valid_q) begin
            if (loaded_q[active_sel_q]) begin
                rd_data_d = ram_rdata;
            end else if (s1_idx_q == '0) begin
                rd_data_d = UNIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            waddr_q        <= '0;
            loaded_q       <= '0;
            active_sel_q   <= 1'b0;
            load_ready_q   <= 1'b0;
            load_done_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swapped_q      <= 1'b0;
`ifdef IR_BANK_CHECKSUM_EN
            sum_q          <= '0;
            load_err_q     <= 1'b0;
`endif
            rd_busy_q      <= 1'b0;
            rd_issue_q     <= 1'b0;
            raddr_q        <= '0;
            s1_valid_q     <= 1'b0;
            s1_idx_q       <= '0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_idx_q       <= '0;
            rd_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            loaded_q       <= loaded_d;
            active_sel_q   <= active_sel_d;
            load_ready_q   <= load_ready_d;
            load_done_q    <= load_done_d;
            swap_pending_q <= swap_pending_d;
            swapped_q      <= swapped_d;
`ifdef IR_BANK_CHECKSUM_EN
            sum_q          <= sum_d;
            load_err_q     <= load_err_d;
`endif
            rd_busy_q      <= rd_busy_d;
            rd_issue_q     <= rd_issue_d;
            raddr_q        <= raddr_d;
            s1_valid_q     <= s1_valid_d;
            s1_idx_q       <= s1_idx_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_idx_q       <= rd_idx_d;
            rd_last_q      <= rd_last_d;
        end
    end

    assign load_ready   = load_ready_q;
    assign load_done    = load_done_q;
    assign swap_pending = swap_pending_q;
    assign swapped      = swapped_q;
`ifdef IR_BANK_CHECKSUM_EN
    assign load_err     = load_err_q;
`endif
    assign rd_busy      = rd_busy_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_idx       = rd_idx_q;
    assign rd_last      = rd_last_q;

endmodule

// File: tb/tb_ir_coeff_bank.sv
// Bench for ir_coeff_bank: table of load patterns plus hand-written swap/restart/reset sequences, stream words scoreboarded.
`timescale 1ns/1ps
module tb_ir_coeff_bank;

    localparam int unsigned TAPS   = 256;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [WORD_W-1:0] load_data = '0;
    logic              load_ready;
    logic              load_done;
    logic [WORD_W-1:0] load_sum = '0;
`ifdef IR_BANK_CHECKSUM_EN
    logic              load_err;
`endif
    logic              commit = 1'b0;
    logic              swap_pending;
    logic              swapped;
    logic              rd_start = 1'b0;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_last;
    logic              rd_busy;

    ir_coeff_bank #(.TAPS(TAPS), .WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_done    (load_done),
`ifdef IR_BANK_CHECKSUM_EN
        .load_sum     (load_sum),
        .load_err     (load_err),
`endif
        .commit       (commit),
        .swap_pending (swap_pending),
        .swapped      (swapped),
        .rd_start     (rd_start),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_idx       (rd_idx),
        .rd_last      (rd_last),
        .rd_busy      (rd_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  idx;
        logic        last;
    } exp_t;

    vec_t        vecs[4];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mbank [2][TAPS];
    logic        mloaded [2];
    logic        mactive;
    logic [15:0] msum;
    logic [15:0] first_word;
    logic [15:0] last_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_word(input int i);
        if (mloaded[mactive]) return mbank[mactive][i];
        return (i == 0) ? 16'h7FFF : 16'h0000;
    endfunction

    // Scoreboard consumer: every valid stream word must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got idx %0d data 0x%0h with no word expected", rd_idx, rd_data);
            end else begin
                e = sb_q.pop_front();
                check("stream_word", 32'({rd_last, rd_idx, rd_data}), 32'({e.last, e.idx, e.data}));
                if (rd_idx == 8'd0) first_word = rd_data;
                if (rd_last) last_word = rd_data;
            end
        end
    end

    task automatic apply_reset();
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        commit     = 1'b0;
        rd_start   = 1'b0;
        #1;
        check("rst_load", 32'({load_ready, load_done, swap_pending, swapped}), 32'h0);
        check("rst_rd_ctl", 32'({rd_valid, rd_busy, rd_last}), 32'h0);
        check("rst_rd_data", 32'({rd_idx, rd_data}), 32'h0);
        sb_q.delete();
        mloaded[0] = 1'b0;
        mloaded[1] = 1'b0;
        mactive    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_words(input logic [15:0] base, input logic [15:0] step, input int n);
        logic        sh;
        logic [15:0] w;
        sh = !mactive;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready_start", 32'(load_ready), 32'h1);
        mloaded[sh] = 1'b0;
        msum = '0;
        for (int i = 0; i < n; i++) begin
            w = base + step * 16'(i);
            load_valid = 1'b1;
            load_data  = w;
            tick();
            mbank[sh][i] = w;
            msum = msum + w;
        end
        load_valid = 1'b0;
        if (n == TAPS) begin
            check("load_done", 32'({load_done, load_ready}), 32'h2);
            mloaded[sh] = 1'b1;
            tick();
            check("load_done_pulse", 32'(load_done), 32'h0);
        end
    endtask

    task automatic commit_now(input logic [15:0] sum);
        load_sum = sum;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_pending", 32'({swapped, swap_pending}), 32'h1);
        tick();
        check("commit_swapped", 32'({swapped, swap_pending}), 32'h2);
        mactive = !mactive;
        tick();
        check("swapped_pulse", 32'(swapped), 32'h0);
    endtask

    task automatic start_stream();
        for (int i = 0; i < TAPS; i++) begin
            sb_q.push_back('{data: model_word(i), idx: 8'(i), last: (i == TAPS - 1)});
        end
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic wait_last();
        int n;
        n = 0;
        while (rd_last !== 1'b1 && n < TAPS + 8) begin
            tick();
            n++;
        end
        check("rd_last_seen", 32'(rd_last), 32'h1);
    endtask

    task automatic run_stream();
        first_word = 16'hDEAD;
        last_word  = 16'hDEAD;
        start_stream();
        check("rd_busy_start", 32'({rd_busy, rd_valid}), 32'h2);
        tick();
        check("rd_latency1", 32'(rd_valid), 32'h0);
        tick();
        check("rd_latency2", 32'(rd_valid), 32'h1);
        wait_last();
        tick();
        check("rd_busy_after_last", 32'(rd_busy), 32'h0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{base: 16'h0000, step: 16'h0001, exp_first: 16'h0000, exp_last: 16'h00FF};
        vecs[1] = '{base: 16'h4000, step: 16'h0040, exp_first: 16'h4000, exp_last: 16'h7FC0};
        vecs[2] = '{base: 16'h8000, step: 16'h0003, exp_first: 16'h8000, exp_last: 16'h82FD};
        vecs[3] = '{base: 16'h1234, step: 16'hFFFF, exp_first: 16'h1234, exp_last: 16'h1135};

        apply_reset();

        // Unloaded bank streams the unit impulse.
        run_stream();
        check("impulse_first", 32'(first_word), 32'h7FFF);
        check("impulse_last", 32'(last_word), 32'h0000);

`ifdef IR_BANK_CHECKSUM_EN
        load_words(16'h0000, 16'h0001, TAPS);
        load_sum = 16'h7F81;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("cksum_err", 32'({load_err, swapped, swap_pending}), 32'h4);
        mloaded[!mactive] = 1'b0;
        tick();
        check("cksum_err_pulse", 32'({load_err, swapped}), 32'h0);
        run_stream();
        check("cksum_err_stream", 32'(first_word), 32'h7FFF);
        load_words(16'h0000, 16'h0001, TAPS);
        commit_now(16'h7F80);
        run_stream();
        check("cksum_ok_last", 32'(last_word), 32'h00FF);
`endif

        for (int v = 0; v < 4; v++) begin
            load_words(vecs[v].base, vecs[v].step, TAPS);
            commit_now(msum);
            run_stream();
            check("vec_first", 32'(first_word), 32'(vecs[v].exp_first));
            check("vec_last", 32'(last_word), 32'(vecs[v].exp_last));
        end

        // Commit outside FULL does nothing.
        load_sum = msum;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_idle_pending", 32'(swap_pending), 32'h0);
        tick();
        check("commit_idle_swapped", 32'(swapped), 32'h0);

        // Commit mid-stream: swap deferred until the frame ends.
        load_words(16'h0100, 16'h0002, TAPS);
        start_stream();
        n = 0;
        while (!(rd_valid === 1'b1 && rd_idx == 8'd10) && n < 50) begin
            tick();
            n++;
        end
        check("reach_idx10", 32'(rd_idx), 32'd10);
        load_sum = msum;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n = 0;
        while (rd_last !== 1'b1 && n < TAPS + 8) begin
            check("pending_hold", 32'({swapped, swap_pending}), 32'h1);
            tick();
            n++;
        end
        check("rd_last_deferred", 32'(rd_last), 32'h1);
        check("pending_at_last", 32'({swapped, swap_pending}), 32'h1);
        tick();
        check("pending_after_last", 32'({rd_busy, swapped, swap_pending}), 32'h1);
        tick();
        check("deferred_swap", 32'({swapped, swap_pending}), 32'h2);
        mactive = !mactive;
        tick();
        run_stream();
        check("deferred_new_first", 32'(first_word), 32'h0100);

        // Restart after 100 words, then full load of 0xFFFF; FULL must ignore further words.
        load_words(16'hAAAA, 16'h0001, 100);
        load_words(16'hFFFF, 16'h0000, TAPS);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            check("full_not_ready", 32'(load_ready), 32'h0);
            tick();
        end
        load_valid = 1'b0;
        commit_now(msum);
        run_stream();
        check("restart_first", 32'(first_word), 32'hFFFF);
        check("restart_last", 32'(last_word), 32'hFFFF);

        // Reset during a load, then during a stream.
        load_words(16'h0300, 16'h0001, 50);
        apply_reset();
        start_stream();
        repeat (20) tick();
        check("pre_reset_busy", 32'({rd_busy, rd_valid}), 32'h3);
        apply_reset();
        run_stream();
        check("post_reset_first", 32'(first_word), 32'h7FFF);
        check("post_reset_last", 32'(last_word), 32'h0000);

        repeat (4) tick();
        check("final_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
